msj_encoder_feedback: RTL

MSJ_ENCODER_FEEDBACK -- requirements
Module: msj_encoder_feedback

---
 rtl/msj_platform_pkg.sv | 38 +++
 rtl/msj_quad_input_filter.sv | 40 ++++
 rtl/msj_encoder_feedback.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/msj_platform_pkg.sv
// Shared types and constants for the encoder feedback block: quadrature state,
// step codes and the minimum control period, plus the quadrature step decoder.
package msj_platform_pkg;

   typedef logic [1:0] quad_state_t;

   typedef enum logic [1:0] {
      STEP_NONE = 2'd0,
      STEP_FWD  = 2'd1,
      STEP_REV  = 2'd2,
      STEP_ERR  = 2'd3
   } step_t;

   localparam logic [31:0] MIN_CONTROL_PERIOD = 32'd2;

   // Position of an {A,B} state along the forward cycle 00->01->11->10.
   function automatic logic [1:0] quad_phase(input quad_state_t s);
      case (s)
         2'b00:   quad_phase = 2'd0;
         2'b01:   quad_phase = 2'd1;
         2'b11:   quad_phase = 2'd2;
         default: quad_phase = 2'd3;
      endcase
   endfunction

   // A phase distance of two means both channels moved at once, which is illegal.
   function automatic step_t quad_decode(input quad_state_t prev, input quad_state_t cur);
      logic [1:0] delta;
      delta = quad_phase(cur) - quad_phase(prev);
      case (delta)
         2'd0:    quad_decode = STEP_NONE;
         2'd1:    quad_decode = STEP_FWD;
         2'd3:    quad_decode = STEP_REV;
         default: quad_decode = STEP_ERR;
      endcase
   endfunction

endpackage

// File: rtl/msj_quad_input_filter.sv
// Two-flop synchronizer followed by a stability filter: the output only follows
// the synchronized input after it has differed for FILTER_LEN consecutive clocks.
module msj_quad_input_filter #(
   parameter int FILTER_LEN = 4
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic filtered
);

   localparam logic [3:0] LAST_COUNT = 4'(FILTER_LEN - 1);

   logic       sync_1;
   logic       sync_2;
   logic [3:0] stable_cnt;

   // Any clock where the input agrees with the filtered value restarts the count,
   // so glitches shorter than FILTER_LEN never reach the output.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_1     <= 1'b0;
         sync_2     <= 1'b0;
         stable_cnt <= '0;
         filtered   <= 1'b0;
      end else begin
         sync_1 <= raw;
         sync_2 <= sync_1;
         if (sync_2 == filtered) begin
            stable_cnt <= '0;
         end else if (stable_cnt == LAST_COUNT) begin
            filtered   <= sync_2;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/msj_encoder_feedback.sv
// Quadrature encoder feedback: filtered decode into a 32-bit position, periodic
// velocity sampling with a controller strobe. Define MSJ_ENCODER_INDEX_EN to let
// the index pulse zero the position.
module msj_encoder_feedback
   import msj_platform_pkg::*;
#(
   parameter int FILTER_LEN = 4,
   parameter int ERR_CNT_W  = 16
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 enc_a,
   input  logic                 enc_b,
   input  logic                 enc_index,
   input  logic                 enable,
   input  logic                 zero_pos,
   input  logic [31:0]          control_period,
   output logic signed [31:0]   position,
   output logic signed [31:0]   velocity,
   output logic                 update_controller,
   output logic                 quad_error,
   output logic [ERR_CNT_W-1:0] error_count
);

   localparam logic [4:0] SETTLE_LAST = 5'(FILTER_LEN + 2);

   logic               filt_a;
   logic               filt_b;
   quad_state_t        cur_state;
   quad_state_t        prev_state;
   step_t              step;
   logic               settled;
   logic [4:0]         settle_cnt;
   logic               zero_req;
   logic signed [31:0] position_next;
   logic signed [31:0] snapshot;
   logic [31:0]        period_cnt;
   logic [31:0]        period_len;
   logic [31:0]        period_req;
   logic               enable_d;

   msj_quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_a (
      .clock    (clock),
      .reset    (reset),
      .raw      (enc_a),
      .filtered (filt_a)
   );

   msj_quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_b (
      .clock    (clock),
      .reset    (reset),
      .raw      (enc_b),
      .filtered (filt_b)
   );

`ifdef MSJ_ENCODER_INDEX_EN
   logic filt_index;
   logic index_prev;

   msj_quad_input_filter #(.FILTER_LEN(FILTER_LEN)) u_filter_index (
      .clock    (clock),
      .reset    (reset),
      .raw      (enc_index),
      .filtered (filt_index)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         index_prev <= 1'b0;
      end else begin
         index_prev <= filt_index;
      end
   end

   assign zero_req = zero_pos | (filt_index & ~index_prev);
`else
   logic unused_index;
   assign unused_index = enc_index;
   assign zero_req     = zero_pos;
`endif

   assign cur_state  = {filt_a, filt_b};
   assign step       = settled ? quad_decode(prev_state, cur_state) : STEP_NONE;
   assign period_req = (control_period < MIN_CONTROL_PERIOD) ? MIN_CONTROL_PERIOD : control_period;

   always_comb begin
      position_next = position;
      if (zero_req) begin
         position_next = '0;
      end else if (step == STEP_FWD) begin
         position_next = position + 32'sd1;
      end else if (step == STEP_REV) begin
         position_next = position - 32'sd1;
      end
   end

   // Decoding is held off until the filters have had time to adopt whatever
   // state the pins sit in after reset, so that state is taken silently.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_state  <= '0;
         settle_cnt  <= '0;
         settled     <= 1'b0;
         position    <= '0;
         quad_error  <= 1'b0;
         error_count <= '0;
      end else begin
         prev_state <= cur_state;
         position   <= position_next;
         quad_error <= (step == STEP_ERR);
         if (!settled) begin
            settle_cnt <= settle_cnt + 5'd1;
            if (settle_cnt == SETTLE_LAST) begin
               settled <= 1'b1;
            end
         end
         if (step == STEP_ERR && error_count != '1) begin
            error_count <= error_count + ERR_CNT_W'(1);
         end
      end
   end

   // The enable edge restarts the period with a fresh snapshot; the period
   // length is only re-latched there and at each wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         enable_d          <= 1'b0;
         period_cnt        <= '0;
         period_len        <= MIN_CONTROL_PERIOD;
         snapshot          <= '0;
         velocity          <= '0;
         update_controller <= 1'b0;
      end else begin
         enable_d          <= enable;
         update_controller <= 1'b0;
         if (!enable) begin
            period_cnt <= '0;
         end else if (!enable_d) begin
            period_cnt <= '0;
            period_len <= period_req;
            snapshot   <= position;
         end else if (period_cnt == period_len - 32'd1) begin
            period_cnt        <= '0;
            period_len        <= period_req;
            velocity          <= position - snapshot;
            snapshot          <= position;
            update_controller <= 1'b1;
         end else begin
            period_cnt <= period_cnt + 32'd1;
         end
         if (zero_req) begin
            snapshot <= '0;
         end
      end
   end

endmodule
